// File: rtl/adc0808_responder_pkg.sv
// Shared types and constants for the ADC0808 bus-functional responder.
// Holds the FSM state encoding and the channel slice geometry.
package adc_pkg;

  localparam int CH_W   = 8;
  localparam int NUM_CH = 8;
  localparam int ADDR_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    DELAY = 3'd2,
    CONV  = 3'd3,
    DONE  = 3'd4
  } adc_state_e;

  typedef logic [NUM_CH-1:0][CH_W-1:0] ch_bank_t;

endpackage

// File: rtl/adc0808_responder_if.sv
// Pin-level bundle between an ADC0808 host (master) and the responder (slave).
interface adc_interface;
  import adc_pkg::*;

  logic              ale;
  logic              start;
  logic              oe;
  logic [ADDR_W-1:0] addr;
  ch_bank_t          ch_data;
  logic              eoc;
  logic [CH_W-1:0]   data_out;
  logic              data_drive;

  modport master (
    output ale, start, oe, addr, ch_data,
    input  eoc, data_out, data_drive
  );

  modport slave (
    input  ale, start, oe, addr, ch_data,
    output eoc, data_out, data_drive
  );

endinterface

// File: rtl/adc0808_responder.sv
// Cycle-accurate ADC0808 model: address latch, start/abort FSM, sample-and-hold
// at conversion begin, and registered eoc / data_out / data_drive pins.
module adc0808_responder
  import adc_pkg::*;
#(
  parameter int CONV_CYCLES = 64,
  parameter int EOC_DELAY   = 8
) (
  input  logic         clk,
  input  logic         reset,
  adc_interface.slave  bus
);

  localparam int DW = (EOC_DELAY   > 1) ? $clog2(EOC_DELAY)   : 1;
  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [DW-1:0] DLY_LOAD  = DW'(EOC_DELAY - 1);
  localparam logic [CW-1:0] CONV_LOAD = CW'(CONV_CYCLES - 1);

  adc_state_e        state_q,      state_d;
  logic              ale_prev_q,   ale_prev_d;
  logic              start_prev_q, start_prev_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DW-1:0]     dly_cnt_q,    dly_cnt_d;
  logic [CW-1:0]     conv_cnt_q,   conv_cnt_d;
  logic [CH_W-1:0]   sample_q,     sample_d;
  logic [CH_W-1:0]   result_q,     result_d;
  logic              eoc_q,        eoc_d;
  logic [CH_W-1:0]   data_out_q,   data_out_d;
  logic              data_drive_q, data_drive_d;

  logic ale_rise, start_rise, start_fall;

  assign ale_rise   =  bus.ale   & ~ale_prev_q;
  assign start_rise =  bus.start & ~start_prev_q;
  assign start_fall = ~bus.start &  start_prev_q;

  always_comb begin
    state_d      = state_q;
    ale_prev_d   = bus.ale;
    start_prev_d = bus.start;
    addr_d       = addr_q;
    dly_cnt_d    = dly_cnt_q;
    conv_cnt_d   = conv_cnt_q;
    sample_d     = sample_q;
    result_d     = result_q;

    // Address latch is independent of the FSM, so a coincident start sees it.
    if (ale_rise) addr_d = bus.addr;

    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d  = CLEAR;
          sample_d = '0;
        end
      end
      CLEAR: begin
        if (start_fall) begin
          state_d   = DELAY;
          dly_cnt_d = DLY_LOAD;
        end
      end
      DELAY: begin
        if (start_rise) begin
          state_d  = CLEAR;
          sample_d = '0;
        end else if (dly_cnt_q == '0) begin
          state_d    = CONV;
          sample_d   = bus.ch_data[addr_q];
          conv_cnt_d = CONV_LOAD;
        end else begin
          dly_cnt_d = dly_cnt_q - DW'(1);
        end
      end
      CONV: begin
        // Abort leaves the previous result visible; only completion updates it.
        if (start_rise) begin
          state_d  = CLEAR;
          sample_d = '0;
        end else if (conv_cnt_q == '0) begin
          state_d  = DONE;
          result_d = sample_q;
        end else begin
          conv_cnt_d = conv_cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    eoc_d        = (state_d != CONV);
    data_out_d   = bus.oe ? result_q : '0;
    data_drive_d = bus.oe;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ale_prev_q   <= 1'b0;
      start_prev_q <= 1'b0;
      addr_q       <= '0;
      dly_cnt_q    <= '0;
      conv_cnt_q   <= '0;
      sample_q     <= '0;
      result_q     <= '0;
      eoc_q        <= 1'b1;
      data_out_q   <= '0;
      data_drive_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ale_prev_q   <= ale_prev_d;
      start_prev_q <= start_prev_d;
      addr_q       <= addr_d;
      dly_cnt_q    <= dly_cnt_d;
      conv_cnt_q   <= conv_cnt_d;
      sample_q     <= sample_d;
      result_q     <= result_d;
      eoc_q        <= eoc_d;
      data_out_q   <= data_out_d;
      data_drive_q <= data_drive_d;
    end
  end

  assign bus.eoc        = eoc_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_drive = data_drive_q;

endmodule

// File: tb/tb_adc0808_responder.sv
// Directed scenarios plus random pin activity against a timestamp-based model.
module tb_adc0808_responder;
  import adc_pkg::*;

  localparam int CONV = 64;
  localparam int DLY  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adc_interface bus();

  adc0808_responder #(.CONV_CYCLES(CONV), .EOC_DELAY(DLY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference: conversion tracked as "cycles since start fell".
  logic       p_ale, p_start, armed, busy;
  int         k;
  logic [2:0] m_addr;
  logic [7:0] m_sample, m_result, m_dout;
  logic       m_eoc, m_drive;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    p_ale = 0; p_start = 0; armed = 0; busy = 0; k = 0;
    m_addr = 0; m_sample = 0; m_result = 0; m_dout = 0;
    m_eoc = 1; m_drive = 0;
  endtask

  task automatic model_step();
    logic a_r, s_r, s_f;
    a_r = bus.ale & ~p_ale;
    s_r = bus.start & ~p_start;
    s_f = ~bus.start & p_start;
    m_dout  = bus.oe ? m_result : 8'h00;
    m_drive = bus.oe;
    if (s_r) begin
      busy = 0; armed = 1;
    end else if (busy) begin
      k++;
      if (k == DLY) m_sample = bus.ch_data[m_addr];
      if (k == DLY + CONV) begin m_result = m_sample; busy = 0; end
    end else if (s_f && armed) begin
      armed = 0; busy = 1; k = 0;
    end
    if (a_r) m_addr = bus.addr;
    p_ale = bus.ale; p_start = bus.start;
    m_eoc = !(busy && k >= DLY);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    #1;
    chk("eoc", bus.eoc, m_eoc);
    chk("data_out", bus.data_out, m_dout);
    chk("data_drive", bus.data_drive, m_drive);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_eoc(input logic lvl, output int n);
    n = 0;
    while (bus.eoc !== lvl && n < 500) begin tick(); n++; end
    chk("wait_eoc", bus.eoc, lvl);
  endtask

  task automatic pulse_start();
    bus.start = 1; ticks(2);
    bus.start = 0; tick();
  endtask

  initial begin
    int n;
    reset = 1;
    bus.ale = 0; bus.start = 0; bus.oe = 0; bus.addr = 0;
    for (int c = 0; c < NUM_CH; c++) bus.ch_data[c] = 8'($urandom);
    model_reset();
    #12;
    chk("rst_eoc", bus.eoc, 1);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_data_drive", bus.data_drive, 0);
    chk("rst_state", dut.state_q, IDLE);
    reset = 0;
    ticks(2);

    // Basic conversion on channel 3 with exact eoc timing.
    bus.ch_data[3] = 8'hA5;
    bus.addr = 3; bus.ale = 1; tick();
    bus.ale = 0; tick();
    pulse_start();
    n = 0; while (bus.eoc && n < 200) begin tick(); n++; end
    chk("eoc_fall_delay", n, DLY);
    n = 0; while (!bus.eoc && n < 200) begin tick(); n++; end
    chk("eoc_low_width", n, CONV);
    bus.oe = 1; tick();
    chk("basic_result", bus.data_out, 8'hA5);
    chk("basic_drive", bus.data_drive, 1);

    // Sample-and-hold: channel change mid-conversion is ignored.
    pulse_start();
    wait_eoc(0, n); ticks(10);
    bus.ch_data[3] = 8'h3C;
    wait_eoc(1, n); tick();
    chk("hold_result", bus.data_out, 8'hA5);

    // Abort 20 cycles into CONV, then a full new conversion.
    pulse_start();
    wait_eoc(0, n); ticks(20);
    bus.start = 1; tick();
    chk("abort_eoc", bus.eoc, 1);
    chk("abort_old_result", bus.data_out, 8'hA5);
    bus.ch_data[3] = 8'h5A;
    tick(); bus.start = 0; tick();
    wait_eoc(0, n);
    chk("abort_restart_delay", n, DLY);
    wait_eoc(1, n);
    chk("abort_restart_width", n, CONV);
    tick();
    chk("abort_new_result", bus.data_out, 8'h5A);

    // Reset in the middle of CONV discards everything.
    pulse_start();
    wait_eoc(0, n); ticks(30);
    #2 reset = 1; #1;
    chk("midrst_eoc", bus.eoc, 1);
    chk("midrst_data_out", bus.data_out, 0);
    chk("midrst_state", dut.state_q, IDLE);
    model_reset();
    ticks(2);
    reset = 0;
    ticks(100);
    chk("midrst_no_result", bus.data_out, 0);

    // ale and start rising together: new address applies.
    bus.ch_data[7] = 8'hFF;
    bus.addr = 7; bus.ale = 1; bus.start = 1; tick();
    bus.ale = 0; tick();
    bus.start = 0; tick();
    wait_eoc(0, n); wait_eoc(1, n); tick();
    chk("ale_start_result", bus.data_out, 8'hFF);

    // oe toggling does not disturb the result latch.
    bus.oe = 0; tick();
    chk("oe_off_data", bus.data_out, 0);
    chk("oe_off_drive", bus.data_drive, 0);
    bus.oe = 1; tick();
    chk("oe_on_data", bus.data_out, 8'hFF);
    chk("oe_on_drive", bus.data_drive, 1);

    // Random pin activity, checked every cycle by the model.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(19, 0) == 0) begin bus.ale = ~bus.ale; bus.addr = 3'($urandom); end
      if ($urandom_range(79, 0) == 0) bus.start = ~bus.start;
      if ($urandom_range(7, 0) == 0)  bus.oe = ~bus.oe;
      if ($urandom_range(3, 0) == 0)  bus.ch_data[$urandom_range(7, 0)] = 8'($urandom);
      if ($urandom_range(1999, 0) == 0) begin
        #2 reset = 1; #1;
        chk("rand_rst_eoc", bus.eoc, 1);
        model_reset();
        tick();
        reset = 0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
